// File: rtl/round_share_arb_if.sv
// -----------------------------------------------------------------------------
// round_share_arb_if
// Handshake bundle between the two sample requesters, the shared rounding
// arbiter and the integer-domain consumer.
//   req0_* / req1_* : requester valid/ready handshake, signed Q4.1 sample, mode
//   out_*           : registered result handshake, signed integer, id, sat flag
// Modports:
//   slave  - the arbiter's view (takes requests, produces results)
//   master - the environment's view (drives requests, consumes results)
// -----------------------------------------------------------------------------
interface round_share_arb_if;
  logic              req0_valid;
  logic              req0_ready;
  logic signed [4:0] req0_data;
  logic        [1:0] req0_mode;
  logic              req1_valid;
  logic              req1_ready;
  logic signed [4:0] req1_data;
  logic        [1:0] req1_mode;
  logic              out_valid;
  logic              out_ready;
  logic signed [3:0] out_data;
  logic              out_id;
  logic              out_sat;

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    input  req1_valid, req1_data, req1_mode,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id, out_sat
  );

  modport master (
    output req0_valid, req0_data, req0_mode,
    output req1_valid, req1_data, req1_mode,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id, out_sat
  );
endinterface

// File: rtl/round_share_arb.sv
// -----------------------------------------------------------------------------
// round_share_arb
// Shares one signed Q4.1 -> 4-bit integer rounding datapath between two
// requesters with round-robin arbitration. Each request carries its own
// rounding mode (ceil, floor, round-half-away, truncate). The result sits in a
// single output register with valid/ready back-pressure; saturated results
// taken by the consumer are counted.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   bus     - request/result handshake bundle (slave side)
//   clr_cnt - synchronous clear of sat_cnt (wins over increment)
//   sat_cnt - saturating count of consumed saturated results
// -----------------------------------------------------------------------------
module round_share_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  round_share_arb_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int DATA_W = 5;
  localparam int RES_W  = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   slot_free;
  logic   grant;
  logic   gnt_id;

  logic signed [DATA_W-1:0] sel_data_p0;
  logic        [1:0]        sel_mode_p0;
  logic signed [RES_W-1:0]  rnd_data_p0;
  logic                     rnd_sat_p0;

  logic signed [RES_W-1:0]  res_data_p1;
  logic                     res_id_p1;
  logic                     res_sat_p1;

  // Q4.1 to integer in a 5-bit intermediate so +7.5 rounded up (=8) is
  // still representable for the saturation check.
  function automatic logic signed [DATA_W-1:0] round_q41(
    input logic signed [DATA_W-1:0] d,
    input logic        [1:0]        mode
  );
    logic signed [DATA_W-1:0] fl;
    logic signed [DATA_W-1:0] up;
    fl = d >>> 1;
    up = fl + {{(DATA_W-1){1'b0}}, d[0]};
    unique case (mode)
      2'b00:   return up;
      2'b01:   return fl;
      2'b10:   return d[DATA_W-1] ? fl : up;
      default: return d[DATA_W-1] ? up : fl;
    endcase
  endfunction

  // Returns {sat, value}; only the positive limit can be exceeded.
  function automatic logic [RES_W:0] sat_q41(
    input logic signed [DATA_W-1:0] r
  );
    if (r > 5'sd7) return {1'b1, 4'b0111};
    return {1'b0, r[RES_W-1:0]};
  endfunction

  // ---- stage p0: arbitration and combinational rounding ----
  always_comb begin
    grant     = 1'b0;
    gnt_id    = ptr;
    slot_free = (state == EMPTY) || bus.out_ready;
    if (slot_free) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant  = 1'b1;
        gnt_id = ptr;
      end else if (bus.req0_valid) begin
        grant  = 1'b1;
        gnt_id = 1'b0;
      end else if (bus.req1_valid) begin
        grant  = 1'b1;
        gnt_id = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant && !gnt_id;
  assign bus.req1_ready = grant &&  gnt_id;

  assign sel_data_p0 = gnt_id ? bus.req1_data : bus.req0_data;
  assign sel_mode_p0 = gnt_id ? bus.req1_mode : bus.req0_mode;
  assign {rnd_sat_p0, rnd_data_p0} = sat_q41(round_q41(sel_data_p0, sel_mode_p0));

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (bus.out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) ptr <= ~gnt_id;
    end
  end

  // ---- stage p1: result register ----
  // Loaded only on a grant, so a drain leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_p1 <= '0;
      res_id_p1   <= 1'b0;
      res_sat_p1  <= 1'b0;
    end else if (grant) begin
      res_data_p1 <= rnd_data_p0;
      res_id_p1   <= gnt_id;
      res_sat_p1  <= rnd_sat_p0;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = res_data_p1;
  assign bus.out_id    = res_id_p1;
  assign bus.out_sat   = res_sat_p1;

  // Counts only results actually handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (clr_cnt) begin
      sat_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && res_sat_p1 && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_round_share_arb.sv
// -----------------------------------------------------------------------------
// tb_round_share_arb
// Directed bench for round_share_arb. A cycle model built from the rounding
// rules (real-valued ceil/floor/round/trunc of d/2, then clamp) and the
// round-robin sharing rules is checked against the DUT every falling edge;
// directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_round_share_arb;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clr_cnt;
  logic [CNT_W-1:0] sat_cnt;

  round_share_arb_if bus ();

  round_share_arb #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .sat_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: value is d/2, rounded per mode, then clamped to +7.
  task automatic mdl_round(input int d, input int mode, output int val, output int sat);
    real x;
    real r;
    x = real'(d) / 2.0;
    case (mode)
      0:       r = $ceil(x);
      1:       r = $floor(x);
      2:       r = (x >= 0.0) ? $floor(x + 0.5) : $ceil(x - 0.5);
      default: r = (x >= 0.0) ? $floor(x) : $ceil(x);
    endcase
    val = int'(r);
    sat = 0;
    if (val > 7) begin
      val = 7;
      sat = 1;
    end
  endtask

  // Model state: what the result slot and counter must hold now.
  int m_full, m_data, m_id, m_sat, m_ptr, m_cnt;
  int e_grant, e_gid, e_val, e_sat;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_full = 0; m_data = 0; m_id = 0; m_sat = 0; m_ptr = 0; m_cnt = 0;
      chk("rst out_valid", int'(bus.out_valid), 0);
      chk("rst out_data", int'(bus.out_data), 0);
      chk("rst out_sat", int'(bus.out_sat), 0);
      chk("rst sat_cnt", int'(sat_cnt), 0);
    end else begin
      e_grant = 0;
      e_gid   = 0;
      if (!m_full || bus.out_ready) begin
        if (bus.req0_valid && bus.req1_valid) begin
          e_grant = 1; e_gid = m_ptr;
        end else if (bus.req0_valid || bus.req1_valid) begin
          e_grant = 1; e_gid = bus.req1_valid ? 1 : 0;
        end
      end
      chk("req0_ready", int'(bus.req0_ready), int'(e_grant == 1 && e_gid == 0));
      chk("req1_ready", int'(bus.req1_ready), int'(e_grant == 1 && e_gid == 1));
      chk("out_valid", int'(bus.out_valid), m_full);
      chk("out_data", int'(bus.out_data), m_data);
      chk("out_id", int'(bus.out_id), m_id);
      chk("out_sat", int'(bus.out_sat), m_sat);
      chk("sat_cnt", int'(sat_cnt), m_cnt);
      // advance to the state after the coming rising edge
      if (clr_cnt) m_cnt = 0;
      else if (m_full == 1 && bus.out_ready && m_sat == 1 && m_cnt < CNT_MAX) m_cnt++;
      if (e_grant == 1) begin
        if (e_gid == 0) mdl_round(int'(bus.req0_data), int'(bus.req0_mode), e_val, e_sat);
        else            mdl_round(int'(bus.req1_data), int'(bus.req1_mode), e_val, e_sat);
        m_full = 1; m_data = e_val; m_sat = e_sat; m_id = e_gid; m_ptr = 1 - e_gid;
      end else if (bus.out_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] mv_data [8] = '{5'b00011, 5'b00011, 5'b00011, 5'b00011,
                              5'b11101, 5'b11101, 5'b11101, 5'b11101};
  int         mv_exp  [8] = '{2, 1, 2, 1, -1, -2, -2, -1};

  initial begin
    rst_n = 1'b0;
    clr_cnt = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_mode = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_mode = '0;
    bus.out_ready = 1'b0;
    repeat (2) cyc();
    chk("lit rst out_valid", int'(bus.out_valid), 0);
    chk("lit rst sat_cnt", int'(sat_cnt), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // round-robin: req0 +1.5 ceil -> 2, req1 -1.5 floor -> -2
    bus.req0_valid = 1'b1; bus.req0_data = 5'sb00011; bus.req0_mode = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_data = 5'sb11101; bus.req1_mode = 2'b01;
    #1;
    chk("lit rr first ready0", int'(bus.req0_ready), 1);
    chk("lit rr first ready1", int'(bus.req1_ready), 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("lit rr out_valid", int'(bus.out_valid), 1);
      chk("lit rr out_id", int'(bus.out_id), i % 2);
      chk("lit rr out_data", int'(bus.out_data), (i % 2) ? -2 : 2);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    cyc();
    chk("lit rr drained", int'(bus.out_valid), 0);

    // back-pressure
    bus.out_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    cyc();
    chk("lit bp out_id", int'(bus.out_id), 0);
    repeat (5) begin
      cyc();
      chk("lit bp hold valid", int'(bus.out_valid), 1);
      chk("lit bp hold data", int'(bus.out_data), 2);
      chk("lit bp no ready0", int'(bus.req0_ready), 0);
      chk("lit bp no ready1", int'(bus.req1_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("lit bp release ready1", int'(bus.req1_ready), 1);
    cyc();
    chk("lit bp b2b id1", int'(bus.out_id), 1);
    chk("lit bp b2b data1", int'(bus.out_data), -2);
    cyc();
    chk("lit bp b2b id0", int'(bus.out_id), 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) cyc();

    // rounding modes, requester 0 alone
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req0_data = mv_data[i];
      bus.req0_mode = 2'(i % 4);
      cyc();
      chk("lit mode out_data", int'(bus.out_data), mv_exp[i]);
      chk("lit mode out_sat", int'(bus.out_sat), 0);
    end
    bus.req0_valid = 1'b0;
    cyc();

    // saturation at +7.5
    bus.req0_valid = 1'b1; bus.req0_data = 5'sb01111; bus.req0_mode = 2'b00;
    cyc();
    chk("lit sat ceil", int'(bus.out_data), 7);
    chk("lit sat ceil flag", int'(bus.out_sat), 1);
    bus.req0_mode = 2'b10;
    cyc();
    chk("lit sat round flag", int'(bus.out_sat), 1);
    bus.req0_mode = 2'b01;
    cyc();
    chk("lit sat floor data", int'(bus.out_data), 7);
    chk("lit sat floor flag", int'(bus.out_sat), 0);
    bus.req0_valid = 1'b0;
    cyc();
    chk("lit sat_cnt two", int'(sat_cnt), 2);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("lit sat_cnt clr", int'(sat_cnt), 0);

    // counter saturation at CNT_MAX
    bus.req0_valid = 1'b1; bus.req0_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("lit cnt ramp", int'(sat_cnt), i);
    end
    bus.req0_valid = 1'b0;
    cyc();
    chk("lit cnt capped", int'(sat_cnt), 3);

    // held saturated result is not counted until consumed
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    bus.out_ready = 1'b0;
    bus.req0_valid = 1'b1;
    cyc();
    chk("lit held sat flag", int'(bus.out_sat), 1);
    repeat (3) cyc();
    chk("lit held no count", int'(sat_cnt), 0);
    bus.req0_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("lit held consumed", int'(sat_cnt), 1);

    // async reset while full and stalled; pointer was left on req1
    bus.out_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 5'sb00011; bus.req0_mode = 2'b00;
    cyc();
    bus.req1_valid = 1'b1;
    cyc();
    chk("lit pre-rst full", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit async rst valid", int'(bus.out_valid), 0);
    chk("lit async rst cnt", int'(sat_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("lit post-rst ready0", int'(bus.req0_ready), 1);
    chk("lit post-rst ready1", int'(bus.req1_ready), 0);
    cyc();
    chk("lit post-rst out_id", int'(bus.out_id), 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/round_share_arb.md
Name: round_share_arb

Overview:
- Shares one signed Q4.1 rounding datapath between two requesters.
- Round-robin arbitration, per-request rounding mode, registered result with valid/ready back-pressure, saturation-event counter.
- Sits between sample producers and the integer-domain consumer; is the sole sequencer of the rounding unit.

Parameters:
CNT_W, 8, width of saturating sat-event counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a sample
req0_ready  output  1  requester 0 sample accepted this cycle (grant)
req0_data  input  5  requester 0 sample, signed Q4.1 (bit0 = 0.5 weight)
req0_mode  input  2  00 ceil, 01 floor, 10 round half away from zero, 11 truncate toward zero
req1_valid / req1_ready / req1_data / req1_mode  same as requester 0
out_valid  output  1  result register holds valid data
out_ready  input  1  consumer takes result
out_data  output  4  signed integer result
out_id  output  1  requester index of result
out_sat  output  1  result was saturated
sat_cnt  output  CNT_W  count of saturated results accepted by consumer, saturates at all-ones
clr_cnt  input  1  synchronous clear of sat_cnt

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_id=0, out_sat=0, sat_cnt=0, priority pointer=0 (req0 preferred). req*_ready combinational, therefore 0 while out slot unavailable.
- Slot free = !out_valid || out_ready. Grant only when slot free.
- Arbitration (combinational): one valid -> grant it; both valid -> grant pointer side; reqN_ready=1 for granted N only; at most one ready per cycle.
- Pointer update on grant: pointer <= ~granted index. No grant -> pointer holds.
- Transfer on grant edge: out_data/out_id/out_sat loaded, out_valid<=1. Latency 1 cycle from accept to out_valid.
- Hold: out_valid=1 && out_ready=0 -> all out_* stable, no grants.
- Drain with no grant: out_valid<=0, out_data/out_id/out_sat keep last value.
- Drain + grant same cycle: new result loaded, out_valid stays 1; throughput 1 result/cycle.
- Two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1). EMPTY->FULL on grant; FULL->EMPTY on out_ready without grant; FULL->FULL on hold or drain+grant.
- Arithmetic, d = 5-bit signed, f = d[0], fl = d[4:1] sign-extended to 5 bits:
  - floor = fl
  - ceil = fl + f
  - round = d>=0 ? fl+f : fl
  - trunc = d>=0 ? fl : fl+f
- 5-bit intermediate; >7 -> out_data=4'b0111, out_sat=1. Only case: d=+7.5 with ceil or round. Below -8 impossible.
- sat_cnt increments when out_valid && out_ready && out_sat; holds at 2^CNT_W-1.
- clr_cnt priority over increment; sat_cnt=0 next cycle.
- req*_data/mode sampled only on the grant cycle; changes while not granted ignored.
- Requester dropping valid before grant: legal, no grant issued.
- rst_n asserted mid-transfer: pending result discarded, pointer back to 0.

Test Plan:
- Modes, single requester, out_ready=1: req0 data 5'b00011 (+1.5) modes 00/01/10/11 -> out_data 2,1,2,1. Data 5'b11101 (-1.5) -> -1,-2,-2,-1. Each result one cycle after grant; out_id=0.
- Saturation: data 5'b01111 (+7.5) mode 00 then 10 -> out_data 7, out_sat=1 both, sat_cnt=2. Mode 01 -> 7, out_sat=0. Then clr_cnt=1 -> sat_cnt=0.
- Round-robin: both valid continuously, out_ready=1 -> grants 0,1,0,1,...; results every cycle with out_id alternating.
- Back-pressure: out_ready=0 for 5 cycles with both valid -> out_* stable, no readys. Release -> first grant to pointer side, back-to-back results.
- Counter saturation: CNT_W=2, four sat results consumed -> sat_cnt 1,2,3,3. A sat result held with out_ready=0 -> no increment.
- Async reset: assert rst_n=0 while FULL with out_ready=0 -> out_valid=0 immediately. Release -> next simultaneous request grants req0.
